// File: rtl/debounce_arbiter.sv
// rtl/debounce_arbiter.sv - shared-timer debouncer for several push buttons with round-robin grant
//
// Purpose: debounces NUM_BTNS noisy buttons using one shared DEBOUNCE_CYCLES timer.
//          Each synchronized input that disagrees with its debounced level requests
//          the timer; the granted button commits only after staying stable for the
//          full count.
// Ports:
//   clk           system clock
//   reset         asynchronous active-high reset
//   noisy         raw button levels, asynchronous to clk
//   debounced     filtered button levels
//   press_pulse   one-cycle strobe when debounced[i] rises
//   release_pulse one-cycle strobe when debounced[i] falls
//   busy          high while the shared timer is granted
//   grant_id      index of the granted button, 0 when idle
// Build option: DEBOUNCE_ARB_FIXED_PRIO_EN selects lowest-index-first arbitration
//               instead of round-robin.
module debounce_arbiter #(
    parameter int NUM_BTNS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] noisy,
    output logic [NUM_BTNS-1:0] debounced,
    output logic [NUM_BTNS-1:0] press_pulse,
    output logic [NUM_BTNS-1:0] release_pulse,
    output logic                busy,
    output logic [2:0]          grant_id
);

    typedef enum logic [1:0] {IDLE, COUNT, COMMIT} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       LAST_BTN = 3'(NUM_BTNS - 1);

    // The timer must hold DEBOUNCE_CYCLES-1 without wrapping.
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("debounce_arbiter: CNT_W too small for DEBOUNCE_CYCLES");
    end

    state_t              state, state_n;
    logic [NUM_BTNS-1:0] sync1, sync2, req;
    logic [CNT_W-1:0]    timer, timer_n;
    logic [NUM_BTNS-1:0] debounced_n, press_n, release_n;
    logic                busy_n;
    logic [2:0]          grant_n;
    logic                req_g;
    logic [2:0]          pick;
    logic                pick_vld;
    logic [2:0]          next_ptr;
`ifndef DEBOUNCE_ARB_FIXED_PRIO_EN
    logic [2:0]          rr_ptr, rr_ptr_n;
`endif

    // Two-flop synchronizer on every button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= noisy;
            sync2 <= sync1;
        end
    end

    assign req = sync2 ^ debounced;

    // Request of the currently granted button; looped to keep index widths exact.
    always_comb begin
        req_g = 1'b0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            if (grant_id == 3'(i)) req_g = req[i];
        end
    end

    // Pointer just past the granted button, wrapping at NUM_BTNS.
    assign next_ptr = (grant_id == LAST_BTN) ? 3'd0 : grant_id + 3'd1;

`ifdef DEBOUNCE_ARB_FIXED_PRIO_EN
    // Lowest-index requester wins: scan downward so the last hit is the lowest.
    always_comb begin
        pick     = 3'd0;
        pick_vld = 1'b0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick     = 3'(i);
                pick_vld = 1'b1;
            end
        end
    end
`else
    // First requester at or after rr_ptr, wrapping modulo NUM_BTNS.
    always_comb begin
        int idx;
        pick     = 3'd0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_BTNS) idx = idx - NUM_BTNS;
            for (int j = 0; j < NUM_BTNS; j++) begin
                if (!pick_vld && (j == idx) && req[j]) begin
                    pick     = 3'(j);
                    pick_vld = 1'b1;
                end
            end
        end
    end
`endif

    always_comb begin
        state_n     = state;
        timer_n     = timer;
        debounced_n = debounced;
        press_n     = '0;
        release_n   = '0;
        busy_n      = busy;
        grant_n     = grant_id;
`ifndef DEBOUNCE_ARB_FIXED_PRIO_EN
        rr_ptr_n    = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    timer_n = '0;
                    busy_n  = 1'b1;
                    grant_n = pick;
                    state_n = COUNT;
                end
            end
            COUNT: begin
                // A bounce back to the committed level beats expiry.
                if (!req_g) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    grant_n = 3'd0;
`ifndef DEBOUNCE_ARB_FIXED_PRIO_EN
                    rr_ptr_n = next_ptr;
`endif
                end else if (timer == LAST_CNT) begin
                    state_n = COMMIT;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            COMMIT: begin
                for (int i = 0; i < NUM_BTNS; i++) begin
                    if (grant_id == 3'(i)) begin
                        debounced_n[i] = ~debounced[i];
                        press_n[i]     = ~debounced[i];
                        release_n[i]   = debounced[i];
                    end
                end
                busy_n  = 1'b0;
                grant_n = 3'd0;
                state_n = IDLE;
`ifndef DEBOUNCE_ARB_FIXED_PRIO_EN
                rr_ptr_n = next_ptr;
`endif
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                grant_n = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            timer         <= '0;
            debounced     <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            busy          <= 1'b0;
            grant_id      <= 3'd0;
`ifndef DEBOUNCE_ARB_FIXED_PRIO_EN
            rr_ptr        <= 3'd0;
`endif
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            debounced     <= debounced_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            busy          <= busy_n;
            grant_id      <= grant_n;
`ifndef DEBOUNCE_ARB_FIXED_PRIO_EN
            rr_ptr        <= rr_ptr_n;
`endif
        end
    end

endmodule

// File: tb/tb_debounce_arbiter.sv
// tb/tb_debounce_arbiter.sv - self-checking bench for debounce_arbiter
module tb_debounce_arbiter;

    localparam int NB = 4;
    localparam int DC = 20;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] noisy = '0;
    logic [NB-1:0] debounced, press_pulse, release_pulse;
    logic          busy;
    logic [2:0]    grant_id;

    always #5 clk = ~clk;

    debounce_arbiter #(.NUM_BTNS(NB), .DEBOUNCE_CYCLES(DC), .CNT_W(CW)) dut (
        .clk(clk),
        .reset(reset),
        .noisy(noisy),
        .debounced(debounced),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .busy(busy),
        .grant_id(grant_id)
    );

    typedef struct {
        longint cyc;
        int     btn;
        logic   rise;
    } ev_t;

    typedef struct {
        int            btn;
        logic          val;
        logic [NB-1:0] exp_db;
    } vec_t;

    ev_t           sb[$];
    int            n_checks = 0;
    int            n_fail = 0;
    longint        cyc = 0;
    int            abort_cnt = 0;
    logic [NB-1:0] prev_db = '0;
    logic          prev_busy = 1'b0;
    logic [NB-1:0] mon_chg;
    ev_t           mon_ev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clean edge on one button: commit expected DC+4 edges later.
    task automatic drive(input int btn, input logic val);
        noisy[btn] = val;
        sb.push_back('{cyc + DC + 4, btn, val});
    endtask

    // Output monitor: every debounced change must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            prev_db   = debounced;
            prev_busy = busy;
        end else begin
            mon_chg = debounced ^ prev_db;
            if ((mon_chg | press_pulse | release_pulse) != '0) begin
                check("press_align", press_pulse, mon_chg & debounced);
                check("release_align", release_pulse, mon_chg & ~debounced);
            end
            if (mon_chg != '0) begin
                check("one_bit_change", $countones(mon_chg), 1);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_change: got debounced %b expected no change (cycle %0d)",
                             debounced, cyc);
                end else begin
                    mon_ev = sb.pop_front();
                    check("event_btn", mon_chg, 64'(1) << mon_ev.btn);
                    check("event_dir", debounced[mon_ev.btn], mon_ev.rise);
                    check("event_cycle", cyc, mon_ev.cyc);
                end
            end
            if (prev_busy && !busy && mon_chg == '0) abort_cnt++;
            prev_db   = debounced;
            prev_busy = busy;
        end
    end

    vec_t   vecs[6];
    longint n0, last_edge;
    int     a0, first_btn, second_btn;
    logic   val;

    initial begin
        vecs[0] = '{0, 1'b1, 4'b0001};
        vecs[1] = '{0, 1'b0, 4'b0000};
        vecs[2] = '{1, 1'b1, 4'b0010};
        vecs[3] = '{1, 1'b0, 4'b0000};
        vecs[4] = '{2, 1'b1, 4'b0100};
        vecs[5] = '{2, 1'b0, 4'b0000};

        // Reset held two cycles, then quiet inputs.
        @(posedge clk);
        #1;
        check("reset_db", debounced, 0);
        check("reset_busy", busy, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_cyc(1000);
        check("idle_db", debounced, 0);
        check("idle_press", press_pulse, 0);
        check("idle_release", release_pulse, 0);
        check("idle_busy", busy, 0);
        check("idle_grant", grant_id, 0);

        // Clean single-button edges; the last one leaves the pointer at 3.
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].btn, vecs[i].val);
            wait_cyc(5);
            check("vec_busy", busy, 1);
            check("vec_grant", grant_id, vecs[i].btn);
            wait_cyc(DC + 5);
            check("vec_db", debounced, vecs[i].exp_db);
            check("vec_busy_done", busy, 0);
        end

        // Simultaneous requests on buttons 2 and 3.
`ifdef DEBOUNCE_ARB_FIXED_PRIO_EN
        first_btn  = 2;
        second_btn = 3;
`else
        first_btn  = 3;
        second_btn = 2;
`endif
        for (int k = 0; k < 2; k++) begin
            val = (k == 0);
            n0 = cyc;
            noisy[2] = val;
            noisy[3] = val;
            sb.push_back('{n0 + DC + 4, first_btn, val});
            sb.push_back('{n0 + 2 * DC + 6, second_btn, val});
            wait_cyc(2 * DC + 12);
            check("pair_db", debounced, val ? 4'b1100 : 4'b0000);
        end

        // Bouncing button 1: nine edges ending high, four granted rises abort.
        a0 = abort_cnt;
        val = 1'b0;
        last_edge = cyc;
        for (int k = 0; k < 9; k++) begin
            val = ~val;
            noisy[1] = val;
            last_edge = cyc;
            if (k < 8) wait_cyc($urandom_range(2, DC - 5));
        end
        sb.push_back('{last_edge + DC + 4, 1, 1'b1});
        wait_cyc(DC + 10);
        check("bounce_aborts", abort_cnt - a0, 4);
        check("bounce_db", debounced, 4'b0010);
        drive(1, 1'b0);
        wait_cyc(DC + 10);
        check("bounce_release_db", debounced, 0);

        // Reset in the middle of a falling count: no release strobe.
        drive(0, 1'b1);
        wait_cyc(DC + 10);
        check("pre_reset_db", debounced, 4'b0001);
        noisy[0] = 1'b0;
        wait_cyc(3 + DC / 2);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_db", debounced, 0);
        check("midreset_release", release_pulse, 0);
        check("midreset_busy", busy, 0);
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(DC + 10);
        check("post_reset_db", debounced, 0);

        // One-cycle dip during the final count cycle aborts, then recommits.
        a0 = abort_cnt;
        n0 = cyc;
        noisy[0] = 1'b1;
        wait_cyc(DC);
        noisy[0] = 1'b0;
        wait_cyc(1);
        noisy[0] = 1'b1;
        sb.push_back('{n0 + 2 * DC + 5, 0, 1'b1});
        wait_cyc(5);
        check("glitch_db_hold", debounced, 0);
        check("glitch_abort", abort_cnt - a0, 1);
        wait_cyc(DC + 10);
        check("glitch_recommit_db", debounced, 4'b0001);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
